// File: rtl/parking_cost_accum.sv
// rtl/parking_cost_accum.sv - per-minute parking charge engine with programmable rate table
//
// Counts sec_tick pulses during a session and charges the per-minute rate for
// {latched location, band of current hour} at the start of every begun minute.
// Cost is reported as whole cents rounded up, saturating at 2**COST_W-1.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   sec_tick                      one-cycle pulse per second
//   start, stop, clear            session control pulses
//   loc                           location, latched on an accepted start
//   hour                          current hour (0-23), sampled at each charge
//   cfg_we, cfg_loc, cfg_band     rate-table write strobe and address
//   cfg_whole, cfg_frac           rate: whole cents and hundredths of a cent per minute
//   cost, minutes                 rounded-up cost and minutes charged this session
//   running, sat, bad_hour        in-session flag, sticky saturation, sticky invalid hour
module parking_cost_accum #(
    parameter int LOC_W   = 3,
    parameter int COST_W  = 14,
    parameter int WHOLE_W = 4,
    parameter int MIN_W   = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sec_tick,
    input  logic               start,
    input  logic               stop,
    input  logic               clear,
    input  logic [LOC_W-1:0]   loc,
    input  logic [4:0]         hour,
    input  logic               cfg_we,
    input  logic [LOC_W-1:0]   cfg_loc,
    input  logic [1:0]         cfg_band,
    input  logic [WHOLE_W-1:0] cfg_whole,
    input  logic [6:0]         cfg_frac,
    output logic [COST_W-1:0]  cost,
    output logic [MIN_W-1:0]   minutes,
    output logic               running,
    output logic               sat,
    output logic               bad_hour
);

    localparam int NENT = (2 ** LOC_W) * 4;
    // Wide enough that cents + one rate can never wrap before the saturation test.
    localparam int ACC_W = ((COST_W > WHOLE_W) ? COST_W : WHOLE_W) + 2;
    localparam logic [ACC_W-1:0] COST_MAX = ACC_W'((2 ** COST_W) - 1);

    typedef enum logic [1:0] {IDLE, RUN, STOPPED} state_t;

    state_t              state;
    logic [COST_W:0]     cents;
    logic [6:0]          frac;
    logic [5:0]          sec_cnt;
    logic [LOC_W-1:0]    loc_q;

    logic [WHOLE_W-1:0]  tbl_whole [NENT];
    logic [6:0]          tbl_frac  [NENT];

    function automatic logic [6:0] default_frac(input int idx);
        int band;
        band = idx % 4;
        if (idx < 4) begin
            case (band)
                0:       return 7'd45;
                1:       return 7'd67;
                2:       return 7'd89;
                default: return 7'd45;
            endcase
        end else begin
            case (band)
                0:       return 7'd34;
                1:       return 7'd56;
                2:       return 7'd78;
                default: return 7'd56;
            endcase
        end
    endfunction

    // Charge datapath: next cents/frac and rounded-up cost if the charge is taken.
    logic [1:0]         band;
    logic [LOC_W+1:0]   idx;
    logic [7:0]         frac_sum;
    logic               carry;
    logic [6:0]         frac_nx;
    logic [ACC_W-1:0]   cents_nx;
    logic [ACC_W-1:0]   ceil_nx;
    logic               hour_bad;

    always_comb begin
        band = 2'd3;
        if (hour < 5'd8)       band = 2'd0;
        else if (hour < 5'd13) band = 2'd1;
        else if (hour < 5'd18) band = 2'd2;
        hour_bad = (hour >= 5'd24);
        idx      = {loc_q, band};
        frac_sum = {1'b0, frac} + {1'b0, tbl_frac[idx]};
        carry    = (frac_sum >= 8'd100);
        frac_nx  = carry ? 7'(frac_sum - 8'd100) : frac_sum[6:0];
        cents_nx = ACC_W'(cents) + ACC_W'(tbl_whole[idx]) + ACC_W'(carry);
        ceil_nx  = cents_nx + ACC_W'(frac_nx != 7'd0);
    end

    // Rate table; a write lands after this edge, so a same-cycle charge sees the old rate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NENT; i++) begin
                tbl_whole[i] <= WHOLE_W'(1);
                tbl_frac[i]  <= default_frac(i);
            end
        end else if (cfg_we) begin
            tbl_whole[{cfg_loc, cfg_band}] <= cfg_whole;
            tbl_frac[{cfg_loc, cfg_band}]  <= (cfg_frac > 7'd99) ? 7'd99 : cfg_frac;
        end
    end

    logic take_start;
    assign take_start = start && (state != RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cents    <= '0;
            frac     <= '0;
            sec_cnt  <= '0;
            loc_q    <= '0;
            cost     <= '0;
            minutes  <= '0;
            running  <= 1'b0;
            sat      <= 1'b0;
            bad_hour <= 1'b0;
        end else if (take_start) begin
            state    <= RUN;
            loc_q    <= loc;
            cents    <= '0;
            frac     <= '0;
            sec_cnt  <= '0;
            cost     <= '0;
            minutes  <= '0;
            running  <= 1'b1;
            sat      <= 1'b0;
            bad_hour <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (sec_tick) begin
                        sec_cnt <= (sec_cnt == 6'd59) ? 6'd0 : sec_cnt + 6'd1;
                        if (sec_cnt == 6'd0) begin
                            if (minutes != '1) minutes <= minutes + MIN_W'(1);
                            if (hour_bad) begin
                                bad_hour <= 1'b1;
                            end else if (!sat) begin
                                if (ceil_nx > COST_MAX) begin
                                    cost <= COST_MAX[COST_W-1:0];
                                    sat  <= 1'b1;
                                end else begin
                                    cents <= cents_nx[COST_W:0];
                                    frac  <= frac_nx;
                                    cost  <= ceil_nx[COST_W-1:0];
                                end
                            end
                        end
                    end
                    if (stop) begin
                        state   <= STOPPED;
                        running <= 1'b0;
                    end
                end
                STOPPED: begin
                    if (clear) begin
                        state    <= IDLE;
                        cents    <= '0;
                        frac     <= '0;
                        sec_cnt  <= '0;
                        cost     <= '0;
                        minutes  <= '0;
                        sat      <= 1'b0;
                        bad_hour <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_parking_cost_accum.sv
// tb/tb_parking_cost_accum.sv - self-checking bench for parking_cost_accum
module tb_parking_cost_accum;

    localparam int LOC_W   = 3;
    localparam int COST_W  = 8;
    localparam int WHOLE_W = 4;
    localparam int MIN_W   = 12;
    localparam int CMAX    = (1 << COST_W) - 1;
    localparam int MMAX    = (1 << MIN_W) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_n, sec_tick, start, stop, clear, cfg_we;
    logic [LOC_W-1:0]   loc, cfg_loc;
    logic [4:0]         hour;
    logic [1:0]         cfg_band;
    logic [WHOLE_W-1:0] cfg_whole;
    logic [6:0]         cfg_frac;
    logic [COST_W-1:0]  cost;
    logic [MIN_W-1:0]   minutes;
    logic               running, sat, bad_hour;

    parking_cost_accum #(
        .LOC_W(LOC_W), .COST_W(COST_W), .WHOLE_W(WHOLE_W), .MIN_W(MIN_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sec_tick(sec_tick), .start(start), .stop(stop),
        .clear(clear), .loc(loc), .hour(hour), .cfg_we(cfg_we), .cfg_loc(cfg_loc),
        .cfg_band(cfg_band), .cfg_whole(cfg_whole), .cfg_frac(cfg_frac),
        .cost(cost), .minutes(minutes), .running(running), .sat(sat), .bad_hour(bad_hour)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: rates and accumulated charge held in hundredths of a cent.
    int m_rate [8][4];
    int m_state;   // 0 idle, 1 running, 2 stopped
    int m_loc, m_total, m_ticks, m_min, m_sat, m_bad;

    task automatic check(input string tag, input logic [31:0] obs, input int exp);
        checks++;
        if (obs !== 32'(exp)) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int band_of(input int h);
        if (h < 8)  return 0;
        if (h < 13) return 1;
        if (h < 18) return 2;
        return 3;
    endfunction

    function automatic int exp_cost();
        if (m_sat != 0) return CMAX;
        return (m_total + 99) / 100;
    endfunction

    task automatic model_zero();
        m_total = 0; m_ticks = 0; m_min = 0; m_sat = 0; m_bad = 0;
    endtask

    task automatic model_reset();
        for (int l = 0; l < 8; l++) begin
            m_rate[l][0] = (l == 0) ? 145 : 134;
            m_rate[l][1] = (l == 0) ? 167 : 156;
            m_rate[l][2] = (l == 0) ? 189 : 178;
            m_rate[l][3] = (l == 0) ? 145 : 156;
        end
        m_state = 0;
        m_loc   = 0;
        model_zero();
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_edge();
        int t;
        if (start && m_state != 1) begin
            m_state = 1;
            m_loc   = int'(loc);
            model_zero();
        end else if (m_state == 1) begin
            if (sec_tick) begin
                if (m_ticks % 60 == 0) begin
                    if (m_min < MMAX) m_min++;
                    if (hour >= 24) begin
                        m_bad = 1;
                    end else if (m_sat == 0) begin
                        t = m_total + m_rate[m_loc][band_of(int'(hour))];
                        if ((t + 99) / 100 > CMAX) m_sat = 1;
                        else m_total = t;
                    end
                end
                m_ticks++;
            end
            if (stop) m_state = 2;
        end else if (m_state == 2 && clear) begin
            m_state = 0;
            model_zero();
        end
        if (cfg_we)
            m_rate[cfg_loc][cfg_band] = int'(cfg_whole) * 100 + ((cfg_frac > 99) ? 99 : int'(cfg_frac));
    endtask

    task automatic check_all(input string tag);
        check({tag, ".cost"},     cost,     exp_cost());
        check({tag, ".minutes"},  minutes,  m_min);
        check({tag, ".running"},  running,  (m_state == 1) ? 1 : 0);
        check({tag, ".sat"},      sat,      m_sat);
        check({tag, ".bad_hour"}, bad_hour, m_bad);
    endtask

    string cur_tag = "init";

    task automatic drive(input bit st, input bit sp, input bit cl, input bit tk, input int hr);
        start = st; stop = sp; clear = cl; sec_tick = tk; hour = 5'(hr);
        model_edge();
        @(posedge clk);
        #1;
        start = 0; stop = 0; clear = 0; sec_tick = 0; cfg_we = 0;
        check_all(cur_tag);
    endtask

    task automatic ticks(input int n, input int hr);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 1, hr);
    endtask

    task automatic cfg_write(input int l, input int b, input int w, input int f);
        cfg_loc = LOC_W'(l); cfg_band = 2'(b); cfg_whole = WHOLE_W'(w); cfg_frac = 7'(f);
        cfg_we = 1;
        drive(0, 0, 0, 0, int'(hour));
    endtask

    initial begin
        rst_n = 0; sec_tick = 0; start = 0; stop = 0; clear = 0; cfg_we = 0;
        loc = 0; cfg_loc = 0; cfg_band = 0; cfg_whole = 0; cfg_frac = 0; hour = 9;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst_n = 1;

        // Rounded-up first minute, then the carry out of the fraction on minute two.
        cur_tag = "t1"; loc = 0;
        drive(1, 0, 0, 0, 9);
        drive(0, 0, 0, 1, 9);
        check("t1_cost_1", cost, 2);
        check("t1_min_1", minutes, 1);
        ticks(60, 9);
        check("t1_cost_2", cost, 4);
        check("t1_min_2", minutes, 2);
        drive(0, 1, 0, 0, 9);

        // Band change between minutes; start straight from STOPPED.
        cur_tag = "t2"; loc = 2;
        drive(1, 0, 0, 0, 7);
        drive(0, 0, 0, 1, 7);
        ticks(60, 8);
        check("t2_cost", cost, 3);
        check("t2_min", minutes, 2);
        drive(0, 1, 0, 0, 8);
        drive(0, 0, 1, 0, 8);

        // Invalid hour: minute counted, no charge, sticky flag.
        cur_tag = "t3"; loc = 0;
        drive(1, 0, 0, 0, 24);
        drive(0, 0, 0, 1, 24);
        check("t3_cost_1", cost, 0);
        check("t3_bad_1", bad_hour, 1);
        ticks(60, 13);
        check("t3_cost_2", cost, 2);
        check("t3_bad_2", bad_hour, 1);
        drive(0, 1, 0, 0, 13);

        // Saturation with a programmed 15.99 rate (frac clamp exercised too).
        cur_tag = "t4";
        hour = 3;
        cfg_write(1, 0, 15, 120);
        loc = 1;
        drive(1, 0, 0, 0, 3);
        ticks(901, 3);
        check("t4_cost_16", cost, 255);
        check("t4_sat_16", sat, 1);
        ticks(60, 3);
        check("t4_cost_17", cost, 255);
        drive(0, 1, 0, 0, 3);
        drive(0, 0, 1, 0, 3);

        // Stop in the same cycle as a minute-boundary tick.
        cur_tag = "t5"; loc = 0;
        drive(1, 0, 0, 0, 9);
        ticks(60, 9);
        drive(0, 1, 0, 1, 9);
        check("t5_cost", cost, 4);
        check("t5_running", running, 0);
        drive(0, 0, 1, 0, 9);
        check("t5_clear_cost", cost, 0);

        // Custom rate, then an asynchronous mid-session reset restores defaults.
        cur_tag = "t6";
        hour = 3;
        cfg_write(0, 0, 9, 0);
        loc = 0;
        drive(1, 0, 0, 0, 3);
        drive(0, 0, 0, 1, 3);
        check("t6_custom", cost, 9);
        #2 rst_n = 0;
        #1;
        model_reset();
        check_all("t6_async_rst");
        @(posedge clk);
        #1 rst_n = 1;
        drive(1, 0, 0, 0, 3);
        ticks(61, 3);
        check("t6_def_loc0", cost, 3);
        drive(0, 1, 0, 0, 3);
        loc = 1;
        drive(1, 0, 0, 0, 3);
        ticks(61, 3);
        check("t6_def_loc1", cost, 3);
        drive(0, 1, 0, 0, 3);

        // Random traffic against the model.
        cur_tag = "rnd";
        hour = 10;
        for (int i = 0; i < 8000; i++) begin
            int r, hr;
            r  = $urandom_range(0, 99);
            hr = int'(hour);
            if ($urandom_range(0, 99) < 2) hr = $urandom_range(0, 25);
            loc = LOC_W'($urandom_range(0, 7));
            if ($urandom_range(0, 99) < 3) begin
                cfg_we    = 1;
                cfg_loc   = LOC_W'($urandom_range(0, 7));
                cfg_band  = 2'($urandom_range(0, 3));
                cfg_whole = WHOLE_W'($urandom_range(0, 15));
                cfg_frac  = 7'($urandom_range(0, 127));
            end
            drive(r < 3, r >= 3 && r < 4, r >= 4 && r < 8, $urandom_range(0, 99) < 80, hr);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/parking_cost_accum.md
# parking_cost_accum

Sequential, parametrised parking-meter charge engine. It counts `sec_tick` pulses during a session and charges one per-minute rate at the start of every begun minute, so partial minutes round up. Each rate is looked up from a programmable table indexed by location and time-of-day band, and the running cost is reported in whole cents (rounded up) with saturation. It sits between the seconds timebase and the display/payment logic. Unlike a purely combinational conversion, the rate can change mid-session when the hour band changes.

## Interface
Parameters:
- `LOC_W`, 3: location select width; table holds `2**LOC_W` locations.
- `COST_W`, 14: cost width in cents; maximum cost is `2**COST_W-1`.
- `WHOLE_W`, 4: width of the whole-cents part of a rate.
- `MIN_W`, 12: width of the elapsed-minute counter.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `sec_tick`  in  1  one-cycle pulse per second.
- `start`  in  1  pulse; begin a session.
- `stop`  in  1  pulse; end a session and freeze cost.
- `clear`  in  1  pulse; return from STOPPED to IDLE.
- `loc`  in  LOC_W  location; latched on accepted `start`.
- `hour`  in  5  current hour, 0–23; sampled at each charge.
- `cfg_we`  in  1  rate-table write strobe.
- `cfg_loc`  in  LOC_W  table write location.
- `cfg_band`  in  2  table write band.
- `cfg_whole`  in  WHOLE_W  rate, whole cents per minute.
- `cfg_frac`  in  7  rate, hundredths of a cent per minute; values above 99 are clamped to 99 on write.
- `cost`  out  COST_W  ceil(accumulated cents), saturated.
- `minutes`  out  MIN_W  minutes charged this session; saturates at all-ones.
- `running`  out  1  high in RUN.
- `sat`  out  1  sticky; cost clamped this session.
- `bad_hour`  out  1  sticky; a charge was attempted with `hour` ≥ 24.

## Operation
- Bands: 0 = hours 0–7, 1 = 8–12, 2 = 13–17, 3 = 18–23. `hour` ≥ 24 is invalid: no charge, but `minutes` still increments and `bad_hour` is set.
- Reset table contents:
  - Location 0: bands 0/1/2/3 = 1.45 / 1.67 / 1.89 / 1.45.
  - All other locations: 1.34 / 1.56 / 1.78 / 1.56.
- Internal state: `cents` (COST_W+1 bits), `frac` (0–99), `sec_cnt` (0–59), latched `loc_q`.
- FSM states:
  - IDLE: outputs zero. On `start`: latch `loc`; clear `cents`, `frac`, `sec_cnt`, `minutes`, `sat`, `bad_hour`; go to RUN.
  - RUN: on `sec_tick` with `sec_cnt`==0, charge. `sec_cnt` increments on every `sec_tick` and wraps 59→0. `stop` → STOPPED. `start` and `clear` are ignored.
  - STOPPED: outputs hold. `clear` → IDLE. `start` → new session, identical to the IDLE `start` action; `start` wins if it arrives with `clear`.
- Charge arithmetic:
  - `s = frac + rate_frac`.
  - If `s` ≥ 100: `frac = s - 100` and carry = 1; otherwise `frac = s` and carry = 0.
  - `cents += rate_whole + carry`.
- Cost output:
  - `cost = cents + (frac != 0)`.
  - If that value exceeds `2**COST_W-1`: `cost` = max, `sat` = 1, and no further accumulation occurs this session.
- Simultaneous events in RUN:
  - `stop` together with `sec_tick`: the tick is processed, including any charge, then the block enters STOPPED.
- Table writes:
  - Allowed in any state.
  - A charge in the same cycle as a write to the same entry uses the old value.
  - A write takes effect from the next charge.
  - Writes are not cleared by `start` or `clear`; only `rst_n` restores the defaults.

## Timing
- Every output is a register.
- A charge on a tick in cycle t is visible on `cost` and `minutes` in cycle t+1.
- `running` rises the cycle after `start` and falls the cycle after `stop`.
- First charge occurs on the first `sec_tick` after `start`. The next charge occurs on tick 61, then every 60 ticks after that.
- `rst_n` low at any time (including mid-session) immediately sets:
  - state = IDLE;
  - all outputs = 0;
  - table = defaults.
- No output glitches on release of reset. Inputs are synchronous to `clk`.

## Test plan
- Reset, `loc`=0, `hour`=9, `start`, 61 ticks → `cost`=2 and `minutes`=1 after tick 1; `cost`=4 (3.34 rounded up) and `minutes`=2 after tick 61.
- `loc`=2, `hour`=7, `start`, tick; set `hour`=8, tick 60 more times → 1.34 + 1.56 = 2.90, so `cost`=3, `minutes`=2.
- `hour`=24, `start`, 1 tick → `cost`=0, `minutes`=1, `bad_hour`=1. Then `hour`=13 and 60 more ticks → `cost`=2, `bad_hour` stays 1.
- `COST_W`=8, `cfg_we` loc 1 band 0 with 15.99, `hour`=3, 16 minutes → cents 255.84, so `cost`=255 and `sat`=1. A 17th minute leaves `cost`=255.
- In RUN, `stop` asserted in the same cycle as a minute-boundary tick → charge is included and `running`=0 next cycle. Then `clear` → `cost`=0.
- Mid-session `rst_n` pulse after writing a custom rate → outputs 0 and state IDLE. A new session is charged at the default 1.45 / 1.34 rates.
